// File: rtl/ex_stage_if.sv
// ex_stage_if: execute-stage bundle with ID/EX inputs, forwarding inputs, EX/MEM outputs and stall
// Ports (master = upstream/pipeline side, slave = ex_stage):
//   read_data1/2, sign_extended_immediate, pc_plus4, rs/rt/rd, ID/EX control, alu_op
//   ex_mem_* / mem_wb_* forwarding sources
//   alu_result, write_data, write_reg, branch_target, zero, branch_taken, EX/MEM control, stall
interface ex_stage_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] read_data1_in, read_data2_in, sign_extended_immediate_in, pc_plus4_in;
  logic [4:0] rs_in, rt_in, rd_in;
  logic reg_dst_in, alu_src_in, mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, branch_in;
  logic [1:0] alu_op_in;
  logic ex_mem_reg_write_in, mem_wb_reg_write_in;
  logic [4:0] ex_mem_rd_in, mem_wb_rd_in;
  logic [DATA_WIDTH-1:0] ex_mem_alu_result_in, mem_wb_write_data_in;
  logic [DATA_WIDTH-1:0] alu_result_out, write_data_out, branch_target_out;
  logic [4:0] write_reg_out;
  logic zero_out, branch_taken_out, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out;
  logic stall_out;
  modport master (
    output read_data1_in, read_data2_in, sign_extended_immediate_in, pc_plus4_in,
           rs_in, rt_in, rd_in, reg_dst_in, alu_src_in, mem_to_reg_in, reg_write_in,
           mem_read_in, mem_write_in, branch_in, alu_op_in,
           ex_mem_reg_write_in, mem_wb_reg_write_in, ex_mem_rd_in, mem_wb_rd_in,
           ex_mem_alu_result_in, mem_wb_write_data_in,
    input  alu_result_out, write_data_out, branch_target_out, write_reg_out, zero_out,
           branch_taken_out, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, stall_out
  );
  modport slave (
    input  read_data1_in, read_data2_in, sign_extended_immediate_in, pc_plus4_in,
           rs_in, rt_in, rd_in, reg_dst_in, alu_src_in, mem_to_reg_in, reg_write_in,
           mem_read_in, mem_write_in, branch_in, alu_op_in,
           ex_mem_reg_write_in, mem_wb_reg_write_in, ex_mem_rd_in, mem_wb_rd_in,
           ex_mem_alu_result_in, mem_wb_write_data_in,
    output alu_result_out, write_data_out, branch_target_out, write_reg_out, zero_out,
           branch_taken_out, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, stall_out
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage with forwarding, ALU, branch resolution and registered EX/MEM state
// Ports: clk, reset_n (async, active-low), bus (ex_stage_if.slave: ID/EX in, forwarding in, EX/MEM out, stall_out)
// EX_MULT_EN: adds the iterative multu unit with HI/LO and mfhi/mflo; without it stall_out is 0
module ex_stage #(parameter int DATA_WIDTH = 32) (
  input logic clk,
  input logic reset_n,
  ex_stage_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  typedef struct packed {
    logic [DW-1:0] alu_result, write_data, branch_target;
    logic [4:0] write_reg;
    logic zero, branch_taken, mem_to_reg, reg_write, mem_read, mem_write;
  } exmem_t;
  exmem_t exmem_q, exmem_d;
  logic [DW-1:0] a, b_fwd, b, r_res, alu_res;
  logic [5:0] funct;
  logic stall, bubble;
  assign funct = bus.sign_extended_immediate_in[5:0];
`ifdef EX_MULT_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(DW + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*DW-1:0] prod_q, prod_d, prod_step;
  logic [DW:0] psum;
  logic is_multu;
  // Shift-add runs for DW-1 BUSY cycles; the final step is folded into the DONE edge
  // so stall lasts exactly DW cycles while HI/LO still see all DW iterations.
  always_comb begin
    is_multu = bus.alu_op_in == 2'b10 && funct == 6'h19;
    psum = {1'b0, prod_q[2*DW-1:DW]} + (prod_q[0] ? {1'b0, mcand_q} : {(DW+1){1'b0}});
    prod_step = {psum, prod_q[DW-1:1]};
    stall = (state_q == IDLE && is_multu) || state_q == BUSY;
    bubble = state_q != IDLE || is_multu;
    state_d = state_q;
    cnt_d = cnt_q;
    mcand_d = mcand_q;
    prod_d = prod_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == IDLE && is_multu) begin
      state_d = BUSY;
      cnt_d = CW'(DW);
      mcand_d = a;
      prod_d = {{DW{1'b0}}, b};
    end
    if (state_q == BUSY) begin
      prod_d = prod_step;
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == CW'(2) ? DONE : BUSY;
    end
    if (state_q == DONE) begin
      {hi_d, lo_d} = prod_step;
      state_d = IDLE;
    end
  end
`else
  assign stall = 1'b0;
  assign bubble = 1'b0;
`endif
  always_comb begin
    a = (bus.ex_mem_reg_write_in && bus.ex_mem_rd_in != 5'd0 && bus.ex_mem_rd_in == bus.rs_in) ? bus.ex_mem_alu_result_in :
        (bus.mem_wb_reg_write_in && bus.mem_wb_rd_in != 5'd0 && bus.mem_wb_rd_in == bus.rs_in) ? bus.mem_wb_write_data_in :
        bus.read_data1_in;
    b_fwd = (bus.ex_mem_reg_write_in && bus.ex_mem_rd_in != 5'd0 && bus.ex_mem_rd_in == bus.rt_in) ? bus.ex_mem_alu_result_in :
            (bus.mem_wb_reg_write_in && bus.mem_wb_rd_in != 5'd0 && bus.mem_wb_rd_in == bus.rt_in) ? bus.mem_wb_write_data_in :
            bus.read_data2_in;
    b = bus.alu_src_in ? bus.sign_extended_immediate_in : b_fwd;
    r_res = '0;
    case (funct)
      6'h20: r_res = a + b;
      6'h22: r_res = a - b;
      6'h24: r_res = a & b;
      6'h25: r_res = a | b;
      6'h2a: r_res = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
`ifdef EX_MULT_EN
      6'h10: r_res = hi_q;
      6'h12: r_res = lo_q;
`endif
      default: r_res = '0;
    endcase
    alu_res = bus.alu_op_in == 2'b00 ? a + b :
              bus.alu_op_in == 2'b01 ? a - b :
              bus.alu_op_in == 2'b11 ? a | b : r_res;
    exmem_d.alu_result = alu_res;
    exmem_d.write_data = b_fwd;
    exmem_d.branch_target = bus.pc_plus4_in + (bus.sign_extended_immediate_in << 2);
    exmem_d.write_reg = bus.reg_dst_in ? bus.rd_in : bus.rt_in;
    exmem_d.zero = alu_res == '0;
    exmem_d.branch_taken = bus.branch_in && alu_res == '0 && !bubble;
    exmem_d.mem_to_reg = bus.mem_to_reg_in && !bubble;
    exmem_d.reg_write = bus.reg_write_in && !bubble;
    exmem_d.mem_read = bus.mem_read_in && !bubble;
    exmem_d.mem_write = bus.mem_write_in && !bubble;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exmem_q <= '0;
`ifdef EX_MULT_EN
      state_q <= IDLE;
      cnt_q <= '0;
      mcand_q <= '0;
      prod_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
`endif
    end else begin
      exmem_q <= exmem_d;
`ifdef EX_MULT_EN
      state_q <= state_d;
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      prod_q <= prod_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
`endif
    end
  end
  assign bus.alu_result_out = exmem_q.alu_result;
  assign bus.write_data_out = exmem_q.write_data;
  assign bus.branch_target_out = exmem_q.branch_target;
  assign bus.write_reg_out = exmem_q.write_reg;
  assign bus.zero_out = exmem_q.zero;
  assign bus.branch_taken_out = exmem_q.branch_taken;
  assign bus.mem_to_reg_out = exmem_q.mem_to_reg;
  assign bus.reg_write_out = exmem_q.reg_write;
  assign bus.mem_read_out = exmem_q.mem_read;
  assign bus.mem_write_out = exmem_q.mem_write;
  assign bus.stall_out = stall;
endmodule
